ic_xbar: RTL and testbench

//  Parametrised NM-master x NS-slave crossbar for the SoC req/gnt + recv/ack memory bus.

---
 rtl/ic_xbar.sv | 222 ++++++++++++++++++++++
 tb/tb_ic_xbar.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_xbar.sv
// ic_xbar: NM-master x NS-slave crossbar for the req/gnt + recv/ack memory bus.
// Each slave arbitrates round-robin among idle masters that decode to it.
// Addresses that hit no slave are answered by a per-master error responder.
//
// state   | meaning
// M_IDLE  | master has nothing outstanding; its request may be granted
// M_WAIT  | master granted; response muxed from latched target until recv & ack
// S_FREE  | slave arbitrating; winner's payload drives s_*, s_req = 1
// S_OWNED | slave serving its owner; s_req = 0 until owner sees recv & ack
module ic_xbar #(
  parameter int                NM        = 2,
  parameter int                NS        = 3,
  parameter logic [NS*32-1:0]  MAP_MATCH = {NS{32'h0}},
  parameter logic [NS*32-1:0]  MAP_MASK  = {NS{32'hFFFF_FFFF}}
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic [NM-1:0]     m_req,
  input  logic [NM-1:0]     m_wen,
  input  logic [4*NM-1:0]   m_strb,
  input  logic [32*NM-1:0]  m_wdata,
  input  logic [32*NM-1:0]  m_addr,
  output logic [NM-1:0]     m_gnt,
  output logic [NM-1:0]     m_recv,
  input  logic [NM-1:0]     m_ack,
  output logic [NM-1:0]     m_error,
  output logic [32*NM-1:0]  m_rdata,
  output logic [NS-1:0]     s_req,
  output logic [NS-1:0]     s_wen,
  output logic [4*NS-1:0]   s_strb,
  output logic [32*NS-1:0]  s_wdata,
  output logic [32*NS-1:0]  s_addr,
  input  logic [NS-1:0]     s_gnt,
  input  logic [NS-1:0]     s_recv,
  output logic [NS-1:0]     s_ack,
  input  logic [NS-1:0]     s_error,
  input  logic [32*NS-1:0]  s_rdata
);

  // Target index NS selects the internal error responder.
  localparam int TW = $clog2(NS + 1);
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [TW-1:0] ERR_TGT = TW'(NS);

  typedef enum logic {M_IDLE, M_WAIT}  mst_state_e;
  typedef enum logic {S_FREE, S_OWNED} slv_state_e;

  logic [NM-1:0] req_v;
  logic [TW-1:0] dec_tgt [NM];

  mst_state_e    mst_q  [NM];
  mst_state_e    mst_d  [NM];
  logic [TW-1:0] tgt_q  [NM];
  logic [TW-1:0] tgt_d  [NM];

  slv_state_e    slv_q  [NS];
  slv_state_e    slv_d  [NS];
  logic [PW-1:0] own_q  [NS];
  logic [PW-1:0] own_d  [NS];
  logic [PW-1:0] ptr_q  [NS];
  logic [PW-1:0] ptr_d  [NS];
  logic          lock_q [NS];
  logic          lock_d [NS];
  logic [PW-1:0] lidx_q [NS];
  logic [PW-1:0] lidx_d [NS];

  logic          win_vld [NS];
  logic [PW-1:0] win_idx [NS];

  // Requests are masked during reset so no grant or s_req escapes in that cycle.
  assign req_v = m_req & {NM{g_resetn}};

  // Address decode: lowest-index hit wins, no hit selects the error responder.
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      dec_tgt[m] = ERR_TGT;
      for (int s = NS - 1; s >= 0; s--) begin
        if ((m_addr[32*m +: 32] & MAP_MASK[32*s +: 32]) == MAP_MATCH[32*s +: 32])
          dec_tgt[m] = TW'(s);
      end
    end
  end

  // Per-slave arbitration, payload mux, ack forwarding and next-state.
  always_comb begin
    s_req   = '0;
    s_wen   = '0;
    s_strb  = '0;
    s_wdata = '0;
    s_addr  = '0;
    s_ack   = '0;
    for (int s = 0; s < NS; s++) begin
      int w;
      int j;
      w          = 0;
      j          = 0;
      win_vld[s] = 1'b0;
      win_idx[s] = '0;
      slv_d[s]   = slv_q[s];
      own_d[s]   = own_q[s];
      ptr_d[s]   = ptr_q[s];
      lock_d[s]  = lock_q[s];
      lidx_d[s]  = lidx_q[s];
      if (slv_q[s] == S_FREE) begin
        // A stalled request keeps its master selected; otherwise round-robin.
        if (lock_q[s] && req_v[lidx_q[s]] && mst_q[lidx_q[s]] == M_IDLE &&
            dec_tgt[lidx_q[s]] == TW'(s)) begin
          win_vld[s] = 1'b1;
          win_idx[s] = lidx_q[s];
        end else begin
          for (int k = NM - 1; k >= 0; k--) begin
            j = (int'(ptr_q[s]) + k) % NM;
            if (req_v[j] && mst_q[j] == M_IDLE && dec_tgt[j] == TW'(s)) begin
              win_vld[s] = 1'b1;
              win_idx[s] = PW'(j);
            end
          end
        end
        if (win_vld[s]) begin
          w                   = int'(win_idx[s]);
          s_req[s]            = 1'b1;
          s_wen[s]            = m_wen[w];
          s_strb[4*s +: 4]    = m_strb[4*w +: 4];
          s_wdata[32*s +: 32] = m_wdata[32*w +: 32];
          s_addr[32*s +: 32]  = m_addr[32*w +: 32];
          if (s_gnt[s]) begin
            slv_d[s]  = S_OWNED;
            own_d[s]  = win_idx[s];
            ptr_d[s]  = PW'((w + 1) % NM);
            lock_d[s] = 1'b0;
          end else begin
            lock_d[s] = 1'b1;
            lidx_d[s] = win_idx[s];
          end
        end else begin
          lock_d[s] = 1'b0;
        end
      end else begin
        lock_d[s] = 1'b0;
        s_ack[s]  = m_ack[own_q[s]];
        if (s_recv[s] && m_ack[own_q[s]])
          slv_d[s] = S_FREE;
      end
    end
  end

  // Per-master grant, response mux (slave or error responder) and next-state.
  always_comb begin
    m_gnt   = '0;
    m_recv  = '0;
    m_error = '0;
    m_rdata = '0;
    for (int m = 0; m < NM; m++) begin
      int  t;
      logic g;
      logic r;
      t        = 0;
      g        = 1'b0;
      r        = 1'b0;
      mst_d[m] = mst_q[m];
      tgt_d[m] = tgt_q[m];
      if (mst_q[m] == M_IDLE) begin
        if (req_v[m]) begin
          if (dec_tgt[m] == ERR_TGT) begin
            g = 1'b1;
          end else begin
            t = int'(dec_tgt[m]);
            g = win_vld[t] && (win_idx[t] == PW'(m)) && s_gnt[t];
          end
        end
        m_gnt[m] = g;
        if (g) begin
          mst_d[m] = M_WAIT;
          tgt_d[m] = dec_tgt[m];
        end
      end else begin
        if (tgt_q[m] == ERR_TGT) begin
          r          = 1'b1;
          m_error[m] = 1'b1;
        end else begin
          t                   = int'(tgt_q[m]);
          r                   = s_recv[t];
          m_error[m]          = s_error[t];
          m_rdata[32*m +: 32] = s_rdata[32*t +: 32];
        end
        m_recv[m] = r;
        if (r && m_ack[m])
          mst_d[m] = M_IDLE;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      for (int m = 0; m < NM; m++) begin
        mst_q[m] <= M_IDLE;
        tgt_q[m] <= '0;
      end
      for (int s = 0; s < NS; s++) begin
        slv_q[s]  <= S_FREE;
        own_q[s]  <= '0;
        ptr_q[s]  <= '0;
        lock_q[s] <= 1'b0;
        lidx_q[s] <= '0;
      end
    end else begin
      for (int m = 0; m < NM; m++) begin
        mst_q[m] <= mst_d[m];
        tgt_q[m] <= tgt_d[m];
      end
      for (int s = 0; s < NS; s++) begin
        slv_q[s]  <= slv_d[s];
        own_q[s]  <= own_d[s];
        ptr_q[s]  <= ptr_d[s];
        lock_q[s] <= lock_d[s];
        lidx_q[s] <= lidx_d[s];
      end
    end
  end

endmodule

// File: tb/tb_ic_xbar.sv
// tb_ic_xbar: directed scenarios for a 2x3 ic_xbar (ROM, RAM, AXI bridge map).
module tb_ic_xbar;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam logic [NS*32-1:0] MATCH = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK  = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic              g_clk = 1'b0;
  logic              g_resetn;
  logic [NM-1:0]     m_req;
  logic [NM-1:0]     m_wen;
  logic [4*NM-1:0]   m_strb;
  logic [32*NM-1:0]  m_wdata;
  logic [32*NM-1:0]  m_addr;
  logic [NM-1:0]     m_gnt;
  logic [NM-1:0]     m_recv;
  logic [NM-1:0]     m_ack;
  logic [NM-1:0]     m_error;
  logic [32*NM-1:0]  m_rdata;
  logic [NS-1:0]     s_req;
  logic [NS-1:0]     s_wen;
  logic [4*NS-1:0]   s_strb;
  logic [32*NS-1:0]  s_wdata;
  logic [32*NS-1:0]  s_addr;
  logic [NS-1:0]     s_gnt;
  logic [NS-1:0]     s_recv;
  logic [NS-1:0]     s_ack;
  logic [NS-1:0]     s_error;
  logic [32*NS-1:0]  s_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  ic_xbar #(.NM(NM), .NS(NS), .MAP_MATCH(MATCH), .MAP_MASK(MASK)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_addr(m_addr),
    .m_gnt(m_gnt), .m_recv(m_recv), .m_ack(m_ack), .m_error(m_error), .m_rdata(m_rdata),
    .s_req(s_req), .s_wen(s_wen), .s_strb(s_strb), .s_wdata(s_wdata), .s_addr(s_addr),
    .s_gnt(s_gnt), .s_recv(s_recv), .s_ack(s_ack), .s_error(s_error), .s_rdata(s_rdata)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_wen = '0; m_strb = '0; m_wdata = '0; m_addr = '0; m_ack = '0;
    s_gnt = '0; s_recv = '0; s_error = '0; s_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    g_resetn = 1'b0;
    step();
    g_resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    g_resetn = 1'b0;
    m_req = 2'b01; m_addr[31:0] = 32'h2000_0000; s_gnt = 3'b010; s_recv = 3'b111; m_ack = 2'b11;
    step(); step();
    tests_run++;
    if ({m_gnt, m_recv, m_error, m_rdata, s_req, s_wen, s_strb, s_wdata, s_addr, s_ack} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt=%b recv=%b err=%b s_req=%b s_ack=%b s_addr=%h exp all zero",
               m_gnt, m_recv, m_error, s_req, s_ack, s_addr);
    end
    clear_inputs();
    g_resetn = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    clear_inputs();
    m_req = 2'b01; m_addr[31:0] = 32'h2000_0010; s_gnt = 3'b010;
    #1;
    tests_run++;
    if (m_gnt !== 2'b01 || s_req !== 3'b010 || s_addr[63:32] !== 32'h2000_0010) begin
      tests_failed++;
      $display("FAIL single_gnt: got gnt=%b s_req=%b ram_addr=%h exp 01 010 20000010",
               m_gnt, s_req, s_addr[63:32]);
    end
    step();
    clear_inputs();
    #1;
    tests_run++;
    if (m_gnt !== 2'b00 || m_recv !== 2'b00 || s_req !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_wait: got gnt=%b recv=%b s_req=%b exp 00 00 000", m_gnt, m_recv, s_req);
    end
    step();
    s_recv = 3'b010; s_rdata[63:32] = 32'hCAFE_F00D;
    #1;
    tests_run++;
    if (m_recv !== 2'b01 || m_rdata[31:0] !== 32'hCAFE_F00D || m_error !== 2'b00 || s_ack !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_resp: got recv=%b rdata=%h err=%b s_ack=%b exp 01 cafef00d 00 000",
               m_recv, m_rdata[31:0], m_error, s_ack);
    end
    m_ack = 2'b01;
    #1;
    tests_run++;
    if (s_ack !== 3'b010) begin
      tests_failed++;
      $display("FAIL single_ack_fwd: got s_ack=%b exp 010", s_ack);
    end
    step();
    clear_inputs();
    #1;
    tests_run++;
    if (m_recv !== 2'b00 || m_rdata !== 64'h0) begin
      tests_failed++;
      $display("FAIL single_idle: got recv=%b rdata=%h exp 00 0", m_recv, m_rdata);
    end
    m_req = 2'b01; m_addr[31:0] = 32'h2000_0014; s_gnt = 3'b010;
    #1;
    tests_run++;
    if (m_gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_regrant: got gnt=%b exp 01", m_gnt);
    end
    step();
    clear_inputs(); s_recv = 3'b010; m_ack = 2'b01;
    step();
    clear_inputs();
  endtask

  task automatic test_arbitration();
    do_reset();
    m_req = 2'b11; m_addr = {32'h2000_0100, 32'h2000_0000}; s_gnt = 3'b010;
    #1;
    tests_run++;
    if (m_gnt !== 2'b01 || s_addr[63:32] !== 32'h2000_0000) begin
      tests_failed++;
      $display("FAIL arb_first: got gnt=%b ram_addr=%h exp 01 20000000", m_gnt, s_addr[63:32]);
    end
    step();
    m_req = 2'b10; s_recv = 3'b010; s_rdata[63:32] = 32'h1111_0000; m_ack = 2'b01;
    #1;
    tests_run++;
    if (m_gnt !== 2'b00 || m_recv !== 2'b01 || m_rdata[31:0] !== 32'h1111_0000) begin
      tests_failed++;
      $display("FAIL arb_owned: got gnt=%b recv=%b rdata0=%h exp 00 01 11110000",
               m_gnt, m_recv, m_rdata[31:0]);
    end
    step();
    s_recv = 3'b000; m_ack = 2'b00; m_req = 2'b11;
    #1;
    tests_run++;
    if (m_gnt !== 2'b10 || s_addr[63:32] !== 32'h2000_0100) begin
      tests_failed++;
      $display("FAIL arb_rr_m1: got gnt=%b ram_addr=%h exp 10 20000100", m_gnt, s_addr[63:32]);
    end
    step();
    m_req = 2'b01; s_recv = 3'b010; s_rdata[63:32] = 32'h2222_0000; m_ack = 2'b10;
    #1;
    tests_run++;
    if (m_gnt !== 2'b00 || m_recv !== 2'b10 || m_rdata !== {32'h2222_0000, 32'h0}) begin
      tests_failed++;
      $display("FAIL arb_m1_resp: got gnt=%b recv=%b rdata=%h exp 00 10 2222000000000000",
               m_gnt, m_recv, m_rdata);
    end
    step();
    s_recv = 3'b000; m_ack = 2'b00; m_req = 2'b01;
    #1;
    tests_run++;
    if (m_gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL arb_m0_after: got gnt=%b exp 01", m_gnt);
    end
    step();
    clear_inputs(); s_recv = 3'b010; m_ack = 2'b01;
    step();
    clear_inputs();
  endtask

  task automatic test_lock();
    // RAM pointer now favours M1; a stalled M0 request must still keep the slave.
    clear_inputs();
    m_req = 2'b01; m_addr[31:0] = 32'h2000_0040;
    #1;
    tests_run++;
    if (s_req !== 3'b010 || s_addr[63:32] !== 32'h2000_0040 || m_gnt !== 2'b00) begin
      tests_failed++;
      $display("FAIL lock_start: got s_req=%b ram_addr=%h gnt=%b exp 010 20000040 00",
               s_req, s_addr[63:32], m_gnt);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      m_req = 2'b11; m_addr[63:32] = 32'h2000_0080;
      #1;
      tests_run++;
      if (s_addr[63:32] !== 32'h2000_0040 || m_gnt !== 2'b00 || s_req !== 3'b010) begin
        tests_failed++;
        $display("FAIL lock_hold[%0d]: got ram_addr=%h gnt=%b s_req=%b exp 20000040 00 010",
                 i, s_addr[63:32], m_gnt, s_req);
      end
      step();
    end
    s_gnt = 3'b010;
    #1;
    tests_run++;
    if (m_gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL lock_grant: got gnt=%b exp 01", m_gnt);
    end
    step();
    m_req = 2'b10; s_gnt = 3'b000; s_recv = 3'b010; m_ack = 2'b01;
    #1;
    tests_run++;
    if (m_recv !== 2'b01) begin
      tests_failed++;
      $display("FAIL lock_m0_resp: got recv=%b exp 01", m_recv);
    end
    step();
    s_recv = 3'b000; m_ack = 2'b00; s_gnt = 3'b010;
    #1;
    tests_run++;
    if (m_gnt !== 2'b10 || s_addr[63:32] !== 32'h2000_0080) begin
      tests_failed++;
      $display("FAIL lock_m1_next: got gnt=%b ram_addr=%h exp 10 20000080", m_gnt, s_addr[63:32]);
    end
    step();
    clear_inputs(); s_recv = 3'b010; m_ack = 2'b10;
    step();
    clear_inputs();
  endtask

  task automatic test_parallel();
    clear_inputs();
    m_req = 2'b11; m_wen = 2'b01; m_strb[3:0] = 4'b0011; m_wdata[31:0] = 32'h1234_5678;
    m_addr = {32'h2000_0200, 32'h0000_0100}; s_gnt = 3'b011;
    #1;
    tests_run++;
    if (m_gnt !== 2'b11 || s_req !== 3'b011) begin
      tests_failed++;
      $display("FAIL par_gnt: got gnt=%b s_req=%b exp 11 011", m_gnt, s_req);
    end
    tests_run++;
    if (s_addr !== {32'h0, 32'h2000_0200, 32'h0000_0100} || s_wen !== 3'b001 ||
        s_strb !== 12'h003 || s_wdata !== {64'h0, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL par_payload: got addr=%h wen=%b strb=%h wdata=%h exp 000000002000020000000100 001 003 000000000000000012345678",
               s_addr, s_wen, s_strb, s_wdata);
    end
    step();
    clear_inputs();
    s_recv = 3'b011; s_rdata = {32'h0, 32'hBBBB_1111, 32'hAAAA_0000}; s_error = 3'b010;
    #1;
    tests_run++;
    if (m_recv !== 2'b11 || m_rdata !== {32'hBBBB_1111, 32'hAAAA_0000} || m_error !== 2'b10 || s_ack !== 3'b000) begin
      tests_failed++;
      $display("FAIL par_route: got recv=%b rdata=%h err=%b s_ack=%b exp 11 bbbb1111aaaa0000 10 000",
               m_recv, m_rdata, m_error, s_ack);
    end
    m_ack = 2'b11;
    #1;
    tests_run++;
    if (s_ack !== 3'b011) begin
      tests_failed++;
      $display("FAIL par_ack: got s_ack=%b exp 011", s_ack);
    end
    step();
    clear_inputs();
    #1;
    tests_run++;
    if (m_recv !== 2'b00 || s_ack !== 3'b000) begin
      tests_failed++;
      $display("FAIL par_done: got recv=%b s_ack=%b exp 00 000", m_recv, s_ack);
    end
  endtask

  task automatic test_unmapped();
    clear_inputs();
    m_req = 2'b10; m_addr[63:32] = 32'h9000_0000; s_rdata = {3{32'hDEAD_BEEF}};
    #1;
    tests_run++;
    if (m_gnt !== 2'b10 || s_req !== 3'b000 || m_recv !== 2'b00) begin
      tests_failed++;
      $display("FAIL unm_gnt: got gnt=%b s_req=%b recv=%b exp 10 000 00", m_gnt, s_req, m_recv);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      m_req = 2'b00; s_recv = 3'b111;
      #1;
      tests_run++;
      if (m_recv !== 2'b10 || m_error !== 2'b10 || m_rdata !== 64'h0 || s_ack !== 3'b000) begin
        tests_failed++;
        $display("FAIL unm_hold[%0d]: got recv=%b err=%b rdata=%h s_ack=%b exp 10 10 0 000",
                 i, m_recv, m_error, m_rdata, s_ack);
      end
      step();
    end
    m_ack = 2'b10;
    step();
    clear_inputs();
    #1;
    tests_run++;
    if (m_recv !== 2'b00 || m_error !== 2'b00) begin
      tests_failed++;
      $display("FAIL unm_done: got recv=%b err=%b exp 00 00", m_recv, m_error);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    m_req = 2'b01; m_addr[31:0] = 32'h2000_0000; s_gnt = 3'b010;
    #1;
    tests_run++;
    if (m_gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL rmid_gnt: got gnt=%b exp 01", m_gnt);
    end
    step();
    m_req = 2'b00; s_gnt = 3'b000; m_ack = 2'b01;
    #1;
    tests_run++;
    if (s_ack !== 3'b010) begin
      tests_failed++;
      $display("FAIL rmid_pre_ack: got s_ack=%b exp 010", s_ack);
    end
    g_resetn = 1'b0;
    step();
    m_req = 2'b01; s_gnt = 3'b010; s_recv = 3'b010;
    #1;
    tests_run++;
    if ({m_gnt, m_recv, m_error, m_rdata, s_req, s_wen, s_strb, s_wdata, s_addr, s_ack} !== '0) begin
      tests_failed++;
      $display("FAIL rmid_outputs: got gnt=%b recv=%b s_req=%b s_ack=%b rdata=%h exp all zero",
               m_gnt, m_recv, s_req, s_ack, m_rdata);
    end
    clear_inputs();
    g_resetn = 1'b1;
    step();
    m_req = 2'b01; m_addr[31:0] = 32'h2000_0020; s_gnt = 3'b010;
    #1;
    tests_run++;
    if (m_gnt !== 2'b01 || s_addr[63:32] !== 32'h2000_0020) begin
      tests_failed++;
      $display("FAIL rmid_fresh_gnt: got gnt=%b ram_addr=%h exp 01 20000020", m_gnt, s_addr[63:32]);
    end
    step();
    clear_inputs();
    s_recv = 3'b010; s_rdata[63:32] = 32'h5A5A_A5A5; m_ack = 2'b01;
    #1;
    tests_run++;
    if (m_recv !== 2'b01 || m_rdata[31:0] !== 32'h5A5A_A5A5) begin
      tests_failed++;
      $display("FAIL rmid_fresh_resp: got recv=%b rdata0=%h exp 01 5a5aa5a5", m_recv, m_rdata[31:0]);
    end
    step();
    clear_inputs();
    #1;
    tests_run++;
    if (m_recv !== 2'b00 || s_req !== 3'b000) begin
      tests_failed++;
      $display("FAIL rmid_fresh_done: got recv=%b s_req=%b exp 00 000", m_recv, s_req);
    end
  endtask

  initial begin
    clear_inputs();
    g_resetn = 1'b0;
    test_reset();
    test_single_read();
    test_arbitration();
    test_lock();
    test_parallel();
    test_unmapped();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
